// File: rtl/cordic_pkg.sv
// Shared types and default constants for the CORDIC sequencer.
// Default parameter values, the sequencer state type and a done-latency helper.
package cordic_pkg;

    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_N_ITER       = 8;
    localparam int unsigned DEF_IDX_W        = 4;
    localparam int unsigned DEF_SCALE_CYCLES = 2;
    // Phase counter holds N_ITER-1 or SCALE_CYCLES-1, both at most 14.
    localparam int unsigned DEF_CNT_W        = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIter,
        StScale,
        StDone
    } state_e;

    // Cycles from the start-sampling edge to the done cycle.
    function automatic int unsigned done_latency(input int unsigned n_iter,
                                                 input int unsigned scale_cycles,
                                                 input logic        k_mode);
        return n_iter + 2 + (k_mode ? scale_cycles : 0);
    endfunction

endpackage

// File: rtl/cordic_iter_cnt.sv
// Loadable down-counter with terminal-count flag.
// Times both the ITER and the SCALE phases of the sequencer.
module cordic_iter_cnt
    import cordic_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC datapath: snapshots operands on start, then
// walks LOAD -> ITER -> (SCALE) -> DONE with fully registered control outputs.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned N_ITER       = DEF_N_ITER,
    parameter int unsigned IDX_W        = DEF_IDX_W,
    parameter int unsigned SCALE_CYCLES = DEF_SCALE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              K_mode,
    input  logic [DATA_W-1:0] x_input,
    input  logic [DATA_W-1:0] y_input,
    input  logic              clr_err,
    output logic              dp_load,
    output logic [DATA_W-1:0] dp_x0,
    output logic [DATA_W-1:0] dp_y0,
    output logic              dp_iter_en,
    output logic [IDX_W-1:0]  dp_iter_idx,
    output logic              dp_scale_en,
    output logic              dp_capture,
    output logic              busy,
    output logic              done,
    output logic              k_mode_q,
    output logic              start_dropped
);

    localparam int unsigned CNT_W = DEF_CNT_W;

    state_e state_d, state_q;

    logic              cnt_load, cnt_dec, cnt_tc;
    logic [CNT_W-1:0]  cnt_val;
    logic              accept;

    logic              dp_load_d, dp_load_q;
    logic              iter_en_d, iter_en_q;
    logic              scale_en_d, scale_en_q;
    logic              capture_d, capture_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [DATA_W-1:0] x0_d, x0_q;
    logic [DATA_W-1:0] y0_d, y0_q;
    logic              k_snap_d, k_snap_q;
    logic              dropped_d, dropped_q;

    cordic_iter_cnt #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                state_d  = StIter;
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(N_ITER - 1);
            end
            StIter: begin
                cnt_dec = 1'b1;
                if (cnt_tc) begin
                    if (k_snap_q) begin
                        state_d  = StScale;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(SCALE_CYCLES - 1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StScale: begin
                cnt_dec = 1'b1;
                if (cnt_tc) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign accept = (state_q == StIdle) && start;

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_comb begin
        dp_load_d  = (state_d == StLoad);
        iter_en_d  = (state_d == StIter);
        scale_en_d = (state_d == StScale);
        capture_d  = (state_d == StDone);
        done_d     = (state_d == StDone);
        busy_d     = (state_d != StIdle);

        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if ((state_q == StIter) && (state_d == StIter)) begin
            idx_d = idx_q + IDX_W'(1);
        end

        x0_d     = accept ? x_input : x0_q;
        y0_d     = accept ? y_input : y0_q;
        k_snap_d = accept ? K_mode  : k_snap_q;

        // A dropped start beats a simultaneous clear.
        dropped_d = dropped_q;
        if (start && (state_q != StIdle)) begin
            dropped_d = 1'b1;
        end else if (clr_err) begin
            dropped_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            dp_load_q  <= 1'b0;
            iter_en_q  <= 1'b0;
            scale_en_q <= 1'b0;
            capture_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            k_snap_q   <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dp_load_q  <= dp_load_d;
            iter_en_q  <= iter_en_d;
            scale_en_q <= scale_en_d;
            capture_q  <= capture_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            idx_q      <= idx_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            k_snap_q   <= k_snap_d;
            dropped_q  <= dropped_d;
        end
    end

    assign dp_load       = dp_load_q;
    assign dp_x0         = x0_q;
    assign dp_y0         = y0_q;
    assign dp_iter_en    = iter_en_q;
    assign dp_iter_idx   = idx_q;
    assign dp_scale_en   = scale_en_q;
    assign dp_capture    = capture_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign k_mode_q      = k_snap_q;
    assign start_dropped = dropped_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: default build (N_ITER=8, SCALE_CYCLES=2)
// plus a minimal build (N_ITER=1, SCALE_CYCLES=1).
module tb_cordic_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    logic       start, K_mode, clr_err;
    logic [7:0] x_input, y_input;
    logic       dp_load, dp_iter_en, dp_scale_en, dp_capture, busy, done, k_mode_q;
    logic       start_dropped;
    logic [7:0] dp_x0, dp_y0;
    logic [3:0] dp_iter_idx;

    logic       b_start, b_k, b_clr;
    logic [7:0] b_x, b_y;
    logic       b_load, b_iter_en, b_scale_en, b_capture, b_busy, b_done, b_kq, b_dropped;
    logic [7:0] b_x0, b_y0;
    logic [3:0] b_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    cordic_seq_ctrl #(
        .DATA_W(8), .N_ITER(8), .IDX_W(4), .SCALE_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .K_mode(K_mode),
        .x_input(x_input), .y_input(y_input), .clr_err(clr_err),
        .dp_load(dp_load), .dp_x0(dp_x0), .dp_y0(dp_y0), .dp_iter_en(dp_iter_en),
        .dp_iter_idx(dp_iter_idx), .dp_scale_en(dp_scale_en), .dp_capture(dp_capture),
        .busy(busy), .done(done), .k_mode_q(k_mode_q), .start_dropped(start_dropped)
    );

    cordic_seq_ctrl #(
        .DATA_W(8), .N_ITER(1), .IDX_W(4), .SCALE_CYCLES(1)
    ) dut_min (
        .clk(clk), .reset(reset), .start(b_start), .K_mode(b_k),
        .x_input(b_x), .y_input(b_y), .clr_err(b_clr),
        .dp_load(b_load), .dp_x0(b_x0), .dp_y0(b_y0), .dp_iter_en(b_iter_en),
        .dp_iter_idx(b_idx), .dp_scale_en(b_scale_en), .dp_capture(b_capture),
        .busy(b_busy), .done(b_done), .k_mode_q(b_kq), .start_dropped(b_dropped)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Returns in cycle 1 (the cycle after the start-sampling edge).
    task automatic start_run(input logic k, input logic [7:0] x, input logic [7:0] y);
        K_mode  = k;
        x_input = x;
        y_input = y;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Returns in the done cycle (or after the cycle budget).
    task automatic run_expect_done(input logic k, input logic [7:0] x, input logic [7:0] y,
                                   input int exp_cycle);
        int c;
        start_run(k, x, y);
        c = 1;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        check_eq("done_cycle", c, exp_cycle);
    endtask

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // Datapath strobes must never overlap.
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("excl", 32'($countones({dp_load, dp_iter_en, dp_scale_en, dp_capture}) > 1),
                     0);
            check_eq("excl_min",
                     32'($countones({b_load, b_iter_en, b_scale_en, b_capture}) > 1), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0; K_mode = 1'b0; clr_err = 1'b0; x_input = '0; y_input = '0;
        b_start = 1'b0; b_k = 1'b0; b_clr = 1'b0; b_x = '0; b_y = '0;
        ticks(2);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_idx", dp_iter_idx, 0);
        check_eq("rst_x0", dp_x0, 0);
        check_eq("rst_drop", start_dropped, 0);
        reset = 1'b0;
        tick();

        // K_mode=0 full sequence
        start_run(1'b0, 8'd16, 8'd16);
        check_eq("t1_load", dp_load, 1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_idx0", dp_iter_idx, 0);
        check_eq("t1_x0", dp_x0, 16);
        check_eq("t1_y0", dp_y0, 16);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t1_iter_en", dp_iter_en, 1);
            check_eq("t1_idx", dp_iter_idx, i);
            check_eq("t1_noload", dp_load, 0);
        end
        tick();
        check_eq("t1_done", done, 1);
        check_eq("t1_capture", dp_capture, 1);
        check_eq("t1_idx_hold", dp_iter_idx, 7);
        tick();
        check_eq("t1_done_low", done, 0);
        check_eq("t1_idle", busy, 0);
        check_eq("t1_idx_idle", dp_iter_idx, 7);

        // K_mode=1 with K_mode toggled mid-run
        start_run(1'b1, 8'd16, 8'd16);
        check_eq("t2_kq", k_mode_q, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) K_mode = 1'b0;
            check_eq("t2_iter_en", dp_iter_en, 1);
            check_eq("t2_idx", dp_iter_idx, i);
        end
        for (int s = 0; s < 2; s++) begin
            tick();
            check_eq("t2_scale", dp_scale_en, 1);
            check_eq("t2_no_iter", dp_iter_en, 0);
            check_eq("t2_kq_hold", k_mode_q, 1);
            check_eq("t2_no_done", done, 0);
        end
        tick();
        check_eq("t2_done", done, 1);
        tick();
        check_eq("t2_idle", busy, 0);

        // Start while busy
        start_run(1'b0, 8'd16, 8'd16);
        d0 = done_cnt;
        ticks(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t3_drop_set", start_dropped, 1);
        ticks(2);
        start = 1'b1; clr_err = 1'b1;
        tick();
        start = 1'b0; clr_err = 1'b0;
        check_eq("t3_set_wins", start_dropped, 1);
        tick();
        check_eq("t3_idx_last", dp_iter_idx, 7);
        tick();
        check_eq("t3_done", done, 1);
        ticks(4);
        check_eq("t3_drop_hold", start_dropped, 1);
        check_eq("t3_idle", busy, 0);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_eq("t3_drop_clr", start_dropped, 0);
        check_eq("t3_one_done", done_cnt - d0, 1);

        // Reset mid-ITER
        start_run(1'b1, 8'd16, 8'd16);
        ticks(5);
        check_eq("t4_idx4", dp_iter_idx, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t4_busy", busy, 0);
        check_eq("t4_iter", dp_iter_en, 0);
        check_eq("t4_idx", dp_iter_idx, 0);
        check_eq("t4_x0", dp_x0, 0);
        check_eq("t4_kq", k_mode_q, 0);
        d0 = done_cnt;
        ticks(12);
        check_eq("t4_no_done", done_cnt - d0, 0);
        run_expect_done(1'b0, 8'h33, 8'hcc, 10);
        check_eq("t4_x0_new", dp_x0, 8'h33);

        // Back-to-back starts
        tick();
        check_eq("t5_idle", busy, 0);
        run_expect_done(1'b0, 8'd3, 8'd4, 10);
        tick();
        run_expect_done(1'b0, 8'd5, 8'd6, 10);
        check_eq("t5_x0", dp_x0, 5);
        check_eq("t5_nodrop", start_dropped, 0);
        tick();
        run_expect_done(1'b1, 8'd7, 8'd8, 12);

        // Minimal configuration
        tick();
        b_k = 1'b1; b_x = 8'h80; b_y = 8'h7f; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check_eq("t6_load", b_load, 1);
        check_eq("t6_x0", b_x0, 8'h80);
        tick();
        check_eq("t6_iter", b_iter_en, 1);
        check_eq("t6_idx", b_idx, 0);
        tick();
        check_eq("t6_scale", b_scale_en, 1);
        check_eq("t6_no_iter", b_iter_en, 0);
        tick();
        check_eq("t6_done", b_done, 1);
        check_eq("t6_capture", b_capture, 1);
        check_eq("t6_y0", b_y0, 8'h7f);
        tick();
        check_eq("t6_idle", b_busy, 0);
        check_eq("t6_x0_hold", b_x0, 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
